// File: rtl/cpu_pkg.sv
// Shared datapath types and register-file geometry for the decode, operand fetch,
// register file and execute stages.
package cpu_pkg;

    localparam int REG_SIZE = 64;
    localparam int NUM_REG  = 32;
    localparam int IDX_W    = $clog2(NUM_REG);

    typedef logic [IDX_W-1:0]    reg_idx_t;
    typedef logic [REG_SIZE-1:0] word_t;

    localparam reg_idx_t ZERO_REG = reg_idx_t'(31);

endpackage

// File: rtl/operand_bypass.sv
// Resolves one source operand: XZR reads as zero, otherwise a same-cycle writeback
// wins over the register file value that does not yet reflect it.
module operand_bypass
    import cpu_pkg::*;
(
    input  reg_idx_t src,
    input  word_t    rf_data,
    input  logic     wb_regwrite,
    input  reg_idx_t wb_rd,
    input  word_t    wb_data,
    output word_t    operand
);

    always_comb begin
        operand = rf_data;
        // src != ZERO_REG on the bypass path, so a write aimed at XZR never matches.
        if (src == ZERO_REG) begin
            operand = '0;
        end else if (wb_regwrite && (wb_rd == src)) begin
            operand = wb_data;
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode->execute pipeline register around the register file read ports, with
// writeback bypass on capture and writeback refresh of operands held during a stall.
module operand_fetch_stage
    import cpu_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     in_valid,
    output logic     in_ready,
    input  reg_idx_t in_rs1,
    input  reg_idx_t in_rs2,
    input  reg_idx_t in_rd,
    input  logic     in_regwrite,
    input  logic     flush,
    output reg_idx_t rf_rreg1,
    output reg_idx_t rf_rreg2,
    input  word_t    rf_rdata1,
    input  word_t    rf_rdata2,
    input  logic     wb_regwrite,
    input  reg_idx_t wb_rd,
    input  word_t    wb_data,
    output logic     out_valid,
    input  logic     out_ready,
    output word_t    out_op1,
    output word_t    out_op2,
    output reg_idx_t out_rd,
    output logic     out_regwrite
);

    logic     valid_q, valid_d;
    logic     regwrite_q, regwrite_d;
    reg_idx_t rd_q, rd_d;
    reg_idx_t rs_q [2];
    reg_idx_t rs_d [2];
    word_t    op_q [2];
    word_t    op_d [2];

    reg_idx_t src_idx  [2];
    word_t    src_data [2];
    word_t    resolved [2];
    logic     capture;

    assign rf_rreg1 = in_rs1;
    assign rf_rreg2 = in_rs2;

    assign src_idx[0]  = in_rs1;
    assign src_idx[1]  = in_rs2;
    assign src_data[0] = rf_rdata1;
    assign src_data[1] = rf_rdata2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bypass
            operand_bypass u_bypass (
                .src         (src_idx[gi]),
                .rf_data     (src_data[gi]),
                .wb_regwrite (wb_regwrite),
                .wb_rd       (wb_rd),
                .wb_data     (wb_data),
                .operand     (resolved[gi])
            );
        end
    endgenerate

    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        rd_d       = rd_q;
        rs_d       = rs_q;
        op_d       = op_q;
        // Flush only kills the entry; data fields keep their last (known) values.
        if (flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
        end else if (capture) begin
            valid_d    = 1'b1;
            regwrite_d = in_regwrite;
            rd_d       = in_rd;
            rs_d[0]    = in_rs1;
            rs_d[1]    = in_rs2;
            op_d       = resolved;
        end else if (valid_q && out_ready) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
        end else if (valid_q) begin
            // Stalled: a writeback to a held source would otherwise be lost.
            for (int i = 0; i < 2; i++) begin
                if (wb_regwrite && (wb_rd == rs_q[i]) && (rs_q[i] != ZERO_REG)) begin
                    op_d[i] = wb_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            for (int i = 0; i < 2; i++) begin
                rs_q[i] <= '0;
                op_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            rs_q       <= rs_d;
            op_q       <= op_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_regwrite = regwrite_q;
    assign out_rd       = rd_q;
    assign out_op1      = op_q[0];
    assign out_op2      = op_q[1];

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench: a register-file model feeds the read ports, expected entries are
// queued on capture and compared when held and when consumed.
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_regwrite, flush;
    logic [4:0]  rf_rreg1, rf_rreg2;
    logic [63:0] rf_rdata1, rf_rdata2;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        out_valid, out_ready;
    logic [63:0] out_op1, out_op2;
    logic [4:0]  out_rd;
    logic        out_regwrite;

    always #5 clk = ~clk;

    operand_fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_rd        (in_rd),
        .in_regwrite  (in_regwrite),
        .flush        (flush),
        .rf_rreg1     (rf_rreg1),
        .rf_rreg2     (rf_rreg2),
        .rf_rdata1    (rf_rdata1),
        .rf_rdata2    (rf_rdata2),
        .wb_regwrite  (wb_regwrite),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_op1      (out_op1),
        .out_op2      (out_op2),
        .out_rd       (out_rd),
        .out_regwrite (out_regwrite)
    );

    // Register file model: writes on the edge, so same-cycle writes read stale.
    logic [63:0] rf [32];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wb_regwrite) begin
            rf[wb_rd] <= wb_data;
        end
    end
    assign rf_rdata1 = rf[rf_rreg1];
    assign rf_rdata2 = rf[rf_rreg2];

    typedef struct {
        logic [63:0] op1;
        logic [63:0] op2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t sb[$];
    bit   exp_valid = 1'b0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] resolve(input logic [4:0] s);
        if (s == 5'd31) return 64'd0;
        if (wb_regwrite && wb_rd == s) return wb_data;
        return rf[s];
    endfunction

    task automatic peek_held();
        check("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
        check("in_ready", {63'd0, in_ready}, {63'd0, (!exp_valid || out_ready)});
        if (exp_valid) begin
            check("held_op1", out_op1, sb[0].op1);
            check("held_op2", out_op2, sb[0].op2);
            check("held_rd", {59'd0, out_rd}, {59'd0, sb[0].rd});
            check("held_regwrite", {63'd0, out_regwrite}, {63'd0, sb[0].rw});
        end else begin
            check("idle_regwrite", {63'd0, out_regwrite}, 64'd0);
        end
    endtask

    // Advance one clock: model the edge from the currently driven inputs, then check.
    task automatic tick();
        bit   cap;
        exp_t e;
        #1;
        cap = in_valid && (!exp_valid || out_ready) && !flush;
        if (exp_valid && flush) begin
            void'(sb.pop_front());
        end else if (exp_valid && out_ready) begin
            e = sb.pop_front();
            check("cons_op1", out_op1, e.op1);
            check("cons_op2", out_op2, e.op2);
            check("cons_rd", {59'd0, out_rd}, {59'd0, e.rd});
            $display("txn rd=%0d rw=%0d op1=%h op2=%h", out_rd, out_regwrite, out_op1, out_op2);
        end else if (exp_valid && wb_regwrite && wb_rd != 5'd31) begin
            if (sb[0].rs1 == wb_rd) sb[0].op1 = wb_data;
            if (sb[0].rs2 == wb_rd) sb[0].op2 = wb_data;
        end
        if (cap) begin
            e.op1 = resolve(in_rs1);
            e.op2 = resolve(in_rs2);
            e.rs1 = in_rs1;
            e.rs2 = in_rs2;
            e.rd  = in_rd;
            e.rw  = in_regwrite;
            sb.push_back(e);
        end
        exp_valid = cap || (exp_valid && !out_ready && !flush);
        @(posedge clk);
        #1;
        peek_held();
    endtask

    task automatic drive(input bit v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input bit rw, input bit ordy);
        in_valid    = v;
        in_rs1      = r1;
        in_rs2      = r2;
        in_rd       = rd;
        in_regwrite = rw;
        out_ready   = ordy;
    endtask

    task automatic wb(input bit en, input logic [4:0] rd, input logic [63:0] d);
        wb_regwrite = en;
        wb_rd       = rd;
        wb_data     = d;
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        wb(0, 0, 0);
        #2;
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_op1", out_op1, 64'd0);
        check("rst_op2", out_op2, 64'd0);
        check("rst_rd", {59'd0, out_rd}, 64'd0);
        check("rst_regwrite", {63'd0, out_regwrite}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        #10 reset = 1'b1;
        @(posedge clk);
        #1;

        // Preload the file through the writeback port while idle.
        wb(1, 5, 64'h11);    tick();
        wb(1, 6, 64'h22);    tick();
        wb(1, 16, 64'h1616); tick();
        wb(1, 7, 64'h77);    tick();
        wb(1, 3, 64'h33);    tick();
        wb(0, 0, 0);

        // 1: plain read, then consume
        drive(1, 5, 6, 1, 1, 1); tick();
        check("t1_op1", out_op1, 64'h11);
        check("t1_op2", out_op2, 64'h22);
        drive(0, 0, 0, 0, 0, 1); tick();

        // 2: same-cycle writeback bypass over a stale file value
        drive(1, 16, 5, 2, 1, 1);
        wb(1, 16, 64'hC0FFEE12380497CD); tick();
        check("t2_op1", out_op1, 64'hC0FFEE12380497CD);
        wb(0, 0, 0);
        // 3: XZR on both sources, back-to-back with consume of test 2
        drive(1, 31, 31, 3, 0, 1);
        wb(1, 31, 64'hCAFEBABEDEADBEEF); tick();
        check("t3_op1", out_op1, 64'd0);
        check("t3_op2", out_op2, 64'd0);
        wb(0, 0, 0);
        drive(0, 0, 0, 0, 0, 1); tick();

        // 4: stalled entry refreshed by a writeback to held rs2
        drive(1, 3, 7, 4, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        wb(1, 7, 64'hDEAD); tick();
        check("t4_op2", out_op2, 64'hDEAD);
        check("t4_op1", out_op1, 64'h33);
        wb(0, 0, 0);
        // rs1==rs2 refresh updates both
        drive(0, 0, 0, 0, 0, 1); tick();
        drive(1, 5, 5, 6, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        wb(1, 5, 64'h5555); tick();
        wb(0, 0, 0);
        check("t4b_op1", out_op1, 64'h5555);
        check("t4b_op2", out_op2, 64'h5555);

        // 5: flush beats consume+capture
        drive(1, 6, 6, 9, 1, 1);
        flush = 1'b1; tick();
        flush = 1'b0;
        check("t5_valid", {63'd0, out_valid}, 64'd0);
        check("t5_regwrite", {63'd0, out_regwrite}, 64'd0);
        check("t5_in_ready", {63'd0, in_ready}, 64'd1);

        // 6: asynchronous reset while FULL
        drive(1, 5, 6, 10, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        #1 reset = 1'b0;
        #1;
        check("t6_valid", {63'd0, out_valid}, 64'd0);
        check("t6_op1", out_op1, 64'd0);
        check("t6_op2", out_op2, 64'd0);
        check("t6_regwrite", {63'd0, out_regwrite}, 64'd0);
        sb.delete();
        exp_valid = 1'b0;
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic against the model
        for (int n = 0; n < 80; n++) begin
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);
            wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), {$urandom, $urandom});
            if ($urandom_range(0, 3) != 0) begin
                wb_rd = ($urandom_range(0, 1) == 1) ? in_rs1 : in_rs2;
            end
            flush = ($urandom_range(0, 9) == 0);
            tick();
        end
        flush = 1'b0;
        wb(0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
